// File: rtl/reg_file_pkg.sv
// +----------------------------------------------------------------------+
// | reg_file_pkg: shared constants, address-width helper, param checks   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_file_pkg;

  localparam int MAX_DEPTH = 256;
  localparam int MAX_NREAD = 4;

  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit params_ok(input int bits, input int depth,
                                   input int nread, input int bypass);
    return (bits >= 1) && (depth >= 2) && (depth <= MAX_DEPTH) &&
           (nread >= 1) && (nread <= MAX_NREAD) &&
           ((bypass == 0) || (bypass == 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// +----------------------------------------------------------------------+
// | reg_file_if: write port and flattened read ports of the register file|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 16,
  parameter int NREAD = 2
);
  localparam int AW = addr_bits(DEPTH);

  logic                  wenable;
  logic [AW-1:0]         waddr;
  logic [BITS-1:0]       wdata;
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*BITS-1:0] rdata;

  modport master (output wenable, output waddr, output wdata, output raddr,
                  input rdata);
  modport slave  (input wenable, input waddr, input wdata, input raddr,
                  output rdata);

endinterface

`default_nettype wire

// File: rtl/reg_file_read_port.sv
// +----------------------------------------------------------------------+
// | reg_file_read_port: one combinational read port with optional bypass |
// | Optional: REG_FILE_ZERO_REG_EN forces reads of entry 0 to zero       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int DEPTH  = 16,
  parameter int BYPASS = 1,
  localparam int AW    = addr_bits(DEPTH)
) (
  input  wire logic                  rst,
  input  wire logic [DEPTH*BITS-1:0] entries,
  input  wire logic                  wenable,
  input  wire logic [AW-1:0]         waddr,
  input  wire logic [BITS-1:0]       wdata,
  input  wire logic [AW-1:0]         raddr,
  output logic      [BITS-1:0]       rdata
);

  logic hit;

  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    // Out-of-range addresses match no entry and therefore read as zero.
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        rdata = entries[i*BITS +: BITS];
        hit   = 1'b1;
      end
    end
    if ((BYPASS != 0) && !rst && wenable && hit && (waddr == raddr)) begin
      rdata = wdata;
    end
`ifdef REG_FILE_ZERO_REG_EN
    if (raddr == '0) begin
      rdata = '0;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// +----------------------------------------------------------------------+
// | reg_file: DEPTH x BITS register file, 1 write port, NREAD read ports |
// | Optional: REG_FILE_ZERO_REG_EN hardwires entry 0 to zero             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int DEPTH  = 16,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input wire logic   clk,
  input wire logic   rst,
  reg_file_if.slave  bus
);

  localparam int AW = addr_bits(DEPTH);

  if (!params_ok(BITS, DEPTH, NREAD, BYPASS)) begin : g_param_check
    $error("reg_file: illegal parameter combination");
  end

  logic [DEPTH*BITS-1:0]  entries;
  logic [NREAD*BITS-1:0]  rdata_all;

`ifdef REG_FILE_ZERO_REG_EN
  localparam int FIRST_ENTRY = 1;
  assign entries[BITS-1:0] = '0;
`else
  localparam int FIRST_ENTRY = 0;
`endif

  // Reset wins over a same-cycle write; out-of-range waddr matches no entry.
  for (genvar i = FIRST_ENTRY; i < DEPTH; i++) begin : g_entry
    logic [BITS-1:0] entry_d;
    logic [BITS-1:0] entry_q;

    always_comb begin
      entry_d = entry_q;
      if (rst) begin
        entry_d = '0;
      end else if (bus.wenable && (bus.waddr == AW'(i))) begin
        entry_d = bus.wdata;
      end
    end

    always_ff @(posedge clk) begin
      entry_q <= entry_d;
    end

    assign entries[i*BITS +: BITS] = entry_q;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    reg_file_read_port #(
      .BITS   (BITS),
      .DEPTH  (DEPTH),
      .BYPASS (BYPASS)
    ) u_read_port (
      .rst     (rst),
      .entries (entries),
      .wenable (bus.wenable),
      .waddr   (bus.waddr),
      .wdata   (bus.wdata),
      .raddr   (bus.raddr[p*AW +: AW]),
      .rdata   (rdata_all[p*BITS +: BITS])
    );
  end

  assign bus.rdata = rdata_all;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// +----------------------------------------------------------------------+
// | tb_reg_file: directed checks of three reg_file configurations        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef REG_FILE_ZERO_REG_EN
  localparam logic [31:0] ZERO_REG_VAL = 32'h0;
`else
  localparam logic [31:0] ZERO_REG_VAL = 32'h5A;
`endif

  always #5 clk = ~clk;

  reg_file_if #(.BITS(32), .DEPTH(16), .NREAD(2)) if_b1  ();
  reg_file_if #(.BITS(32), .DEPTH(16), .NREAD(2)) if_b0  ();
  reg_file_if #(.BITS(32), .DEPTH(12), .NREAD(2)) if_d12 ();

  reg_file #(.BITS(32), .DEPTH(16), .NREAD(2), .BYPASS(1)) u_dut_b1 (
    .clk (clk), .rst (rst), .bus (if_b1.slave));
  reg_file #(.BITS(32), .DEPTH(16), .NREAD(2), .BYPASS(0)) u_dut_b0 (
    .clk (clk), .rst (rst), .bus (if_b0.slave));
  reg_file #(.BITS(32), .DEPTH(12), .NREAD(2), .BYPASS(1)) u_dut_d12 (
    .clk (clk), .rst (rst), .bus (if_d12.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus to all three instances, then settle before sampling.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ra0, input logic [3:0] ra1);
    if_b1.wenable  = we; if_b1.waddr  = wa; if_b1.wdata  = wd; if_b1.raddr  = {ra1, ra0};
    if_b0.wenable  = we; if_b0.waddr  = wa; if_b0.wdata  = wd; if_b0.raddr  = {ra1, ra0};
    if_d12.wenable = we; if_d12.waddr = wa; if_d12.wdata = wd; if_d12.raddr = {ra1, ra0};
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
    tick();
    tick();

    // Write during reset is dropped and not bypassed.
    drive(1'b1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd5);
    chk("rst_nobypass_b1", if_b1.rdata[31:0], 32'h0);
    chk("rst_nobypass_d12", if_d12.rdata[31:0], 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 4'd5, 4'd5);
    chk("rst_drop_b1", if_b1.rdata[31:0], 32'h0);
    chk("rst_drop_b0", if_b0.rdata[63:32], 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'(i), 4'(15 - i));
      chk($sformatf("reset_p0_a%0d", i), if_b1.rdata[31:0], 32'h0);
      chk($sformatf("reset_p1_a%0d", 15 - i), if_b1.rdata[63:32], 32'h0);
    end

    // Two writes then a dual read.
    drive(1'b1, 4'd3, 32'h0000000A, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd7, 32'h0000000B, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd3);
    chk("dual_p0_b1", if_b1.rdata[31:0], 32'h0000000B);
    chk("dual_p1_b1", if_b1.rdata[63:32], 32'h0000000A);
    chk("dual_p0_b0", if_b0.rdata[31:0], 32'h0000000B);
    chk("dual_p1_d12", if_d12.rdata[63:32], 32'h0000000A);

    // Bypass versus stored-state read.
    drive(1'b1, 4'd4, 32'h11, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd4, 32'h22, 4'd4, 4'd3);
    chk("byp_pre_b1", if_b1.rdata[31:0], 32'h22);
    chk("byp_pre_b0", if_b0.rdata[31:0], 32'h11);
    chk("byp_pre_d12", if_d12.rdata[31:0], 32'h22);
    chk("byp_other_port", if_b1.rdata[63:32], 32'h0000000A);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd4, 4'd4);
    chk("byp_post_b1", if_b1.rdata[31:0], 32'h22);
    chk("byp_post_b0", if_b0.rdata[63:32], 32'h22);

    // Out-of-range write/read on the 12-entry instance.
    drive(1'b1, 4'd11, 32'h77, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd13, 32'hFF, 4'd13, 4'd11);
    chk("oor_pre_d12", if_d12.rdata[31:0], 32'h0);
    chk("oor_pre_b1", if_b1.rdata[31:0], 32'hFF);
    chk("oor_pre_b0", if_b0.rdata[31:0], 32'h0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd13, 4'd11);
    chk("oor_rd13_d12", if_d12.rdata[31:0], 32'h0);
    chk("oor_rd11_d12", if_d12.rdata[63:32], 32'h77);
    chk("oor_rd13_b1", if_b1.rdata[31:0], 32'hFF);
    drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd15);
    chk("oor_rd3_d12", if_d12.rdata[31:0], 32'h0000000A);
    chk("oor_rd15_d12", if_d12.rdata[63:32], 32'h0);

    // Entry 0: ordinary register or hardwired zero.
    drive(1'b1, 4'd0, 32'h5A, 4'd0, 4'd0);
    chk("zero_pre_b1_p0", if_b1.rdata[31:0], ZERO_REG_VAL);
    chk("zero_pre_b0_p1", if_b0.rdata[63:32], 32'h0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
    chk("zero_post_b1_p0", if_b1.rdata[31:0], ZERO_REG_VAL);
    chk("zero_post_b1_p1", if_b1.rdata[63:32], ZERO_REG_VAL);
    chk("zero_post_b0_p0", if_b0.rdata[31:0], ZERO_REG_VAL);

    // Back-to-back writes to addr 2 observed on port 1.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 4'd2, 32'(k), 4'd0, 4'd2);
      chk($sformatf("b2b_b1_w%0d", k), if_b1.rdata[63:32], 32'(k));
      chk($sformatf("b2b_b0_w%0d", k), if_b0.rdata[63:32], 32'(k - 1));
      tick();
    end
    drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd2);
    chk("b2b_hold_b1", if_b1.rdata[63:32], 32'h3);
    chk("b2b_hold_b0", if_b0.rdata[63:32], 32'h3);
    tick();
    chk("b2b_hold2_b1", if_b1.rdata[63:32], 32'h3);

    // Reset mid-sequence with a concurrent write, then a write right after.
    rst = 1'b1;
    drive(1'b1, 4'd9, 32'h99, 4'd3, 4'd9);
    chk("midrst_stored_b1", if_b1.rdata[31:0], 32'h0000000A);
    chk("midrst_nobyp_b1", if_b1.rdata[63:32], 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 4'd9, 32'h12, 4'd3, 4'd9);
    chk("postrst_cleared_b1", if_b1.rdata[31:0], 32'h0);
    chk("postrst_byp_b1", if_b1.rdata[63:32], 32'h12);
    chk("postrst_nobyp_b0", if_b0.rdata[63:32], 32'h0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'd9, 4'd9);
    chk("postrst_wr_b1", if_b1.rdata[31:0], 32'h12);
    chk("postrst_wr_b0", if_b0.rdata[63:32], 32'h12);
    chk("postrst_wr_d12", if_d12.rdata[31:0], 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parametrised multi-port register file. It is the successor to the single-register Reg block.
- DEPTH entries of BITS bits, one synchronous write port, and NREAD combinational read ports with optional write-to-read bypass.
- Serves as the CPU's architectural register file, between decode (read addresses) and writeback (write port).

Parameters:
- BITS, 32, width of each entry.
- DEPTH, 16, number of entries; legal range 2..256; need not be a power of two.
- NREAD, 2, number of read ports; legal range 1..4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads see only stored state.
- AW, $clog2(DEPTH) (localparam, not overridable), address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- wenable  in  1  write strobe, sampled at posedge.
- waddr  in  AW  write address.
- wdata  in  BITS  write data.
- raddr  in  NREAD*AW  read addresses, port p at bits [p*AW +: AW].
- rdata  out  NREAD*BITS  read data, port p at bits [p*BITS +: BITS].

Behaviour:
- Reset: rst high at a posedge clears every entry to 0. rst has priority over wenable in the same cycle; that write is dropped.
- Write: wenable=1 and waddr<DEPTH at a posedge, with rst=0, stores wdata. Visible in stored state from the following cycle.
- Write with waddr>=DEPTH (non-power-of-two DEPTH) is ignored; no entry changes.
- Read: rdata for each port is purely combinational from raddr and current state; zero-cycle latency; no read enable.
- Read with raddr>=DEPTH returns 0.
- Ports are independent; any number of ports may read the same address simultaneously.
- Bypass, BYPASS=1: if wenable=1, rst=0 and raddr[p]==waddr<DEPTH, then rdata[p]=wdata in the same cycle.
- Bypass, BYPASS=0: rdata[p] shows the old value until the posedge.
- Bypass is suppressed while rst=1. With rst=1, rdata reflects stored contents until the reset edge, then 0 afterwards.
- Reset mid-sequence: a write and a reset in the same cycle leave the entry 0. A write in the cycle after reset deassertion takes effect normally.
- No X propagation: all outputs are defined at all times after the first reset edge.
- Before the first reset edge, entry contents are undefined; the bench must apply reset first.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero.
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 on every port.
  - No bypass from a write to address 0.
  - Storage for entry 0 is not instantiated.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Package reg_file_pkg holds:
  - constants MAX_DEPTH=256 and MAX_NREAD=4;
  - function addr_bits(depth) returning $clog2(depth), min 1;
  - elaboration-time parameter checks.
- Sub-module reg_file_read_port, instantiated NREAD times via generate. Parameters BITS, DEPTH, BYPASS. It contains:
  - the entry-select mux;
  - the out-of-range zeroing;
  - the bypass compare;
  - the zero-register gating.
- reg_file owns only the storage array and the write/reset logic.

Test Plan:
- Reset, then read all addresses on both ports -> every rdata = 0. Write 0xDEADBEEF to addr 5 in the same cycle as rst=1 -> addr 5 still reads 0.
- Write 0x0000000A to addr 3, then 0x0000000B to addr 7; next cycle raddr={7,3} -> rdata port0=0x0000000B, port1=0x0000000A.
- BYPASS=1, stored addr 4=0x11, write 0x22 to addr 4 with raddr port0=4 -> rdata port0=0x22 before the edge; after the edge still 0x22.
- Same stimulus with BYPASS=0 -> 0x11 before the edge, 0x22 after.
- DEPTH=12: write 0xFF to addr 13 -> no entry changes; read addr 13 -> 0; read addr 11 -> unchanged.
- With REG_FILE_ZERO_REG_EN: write 0x5A to addr 0 -> both ports reading addr 0 return 0, and no bypass. Without the macro -> 0x5A from the next cycle (same cycle with BYPASS=1).
- Back-to-back writes to addr 2 (0x1, 0x2, 0x3) on consecutive cycles while port1 reads addr 2 with BYPASS=1 -> rdata port1 shows 0x1, 0x2, 0x3 in the matching cycles, then holds 0x3 with wenable=0.
